// File: rtl/muldiv_unit_if.sv
// Operand, MTHI/MTLO and result bundle between the EX forwarding muxes / hazard unit and muldiv_unit.
// Abort is present only when MULDIV_ABORT_EN is defined.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
`ifdef MULDIV_ABORT_EN
  logic             Abort;
`endif
  logic [1:0]       Op;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic             HiWrite;
  logic             LoWrite;
  logic [WIDTH-1:0] WrData;
  logic             Busy;
  logic             Done;
  logic             DivByZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

`ifdef MULDIV_ABORT_EN
  modport master (
    output Start, Abort, Op, OpA, OpB, HiWrite, LoWrite, WrData,
    input  Busy, Done, DivByZero, Hi, Lo
  );
  modport slave (
    input  Start, Abort, Op, OpA, OpB, HiWrite, LoWrite, WrData,
    output Busy, Done, DivByZero, Hi, Lo
  );
`else
  modport master (
    output Start, Op, OpA, OpB, HiWrite, LoWrite, WrData,
    input  Busy, Done, DivByZero, Hi, Lo
  );
  modport slave (
    input  Start, Op, OpA, OpB, HiWrite, LoWrite, WrData,
    output Busy, Done, DivByZero, Hi, Lo
  );
`endif
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; WIDTH+1 cycles from Start to Done, Busy stalls the pipe, Start while Busy is dropped.
// Optional MULDIV_ABORT_EN adds Abort, which cancels an in-flight operation without touching HI/LO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          Clk,
  input logic          Rst,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_nxt;
  logic [1:0]       op;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo;
  logic             done, dbz;
  logic             abort;

`ifdef MULDIV_ABORT_EN
  assign abort = bus.Abort;
`else
  assign abort = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  // Op[0]==0 selects the signed variants (MULT, DIV)
  logic             in_signed;
  assign in_signed = ~bus.Op[0];

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic               neg_res;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    neg_res   = sign_a ^ sign_b;
    prod      = {acc_hi, acc_lo};
    prod_fix  = neg_res ? -prod : prod;
    quot_fix  = neg_res ? -acc_lo : acc_lo;
    // remainder follows the dividend; with a zero divisor it is |OpA|, so this restores OpA
    rem_fix   = sign_a ? -acc_hi : acc_hi;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.Start) state_nxt = RUN;
      RUN:     if (abort) state_nxt = IDLE;
               else if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      op     <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      opb    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      done <= 1'b0;
      dbz  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.HiWrite) hi <= bus.WrData;
          if (bus.LoWrite) lo <= bus.WrData;
          if (bus.Start) begin
            op     <= bus.Op;
            sign_a <= in_signed & bus.OpA[WIDTH-1];
            sign_b <= in_signed & bus.OpB[WIDTH-1];
            opb    <= mag(bus.OpB, in_signed);
            acc_hi <= '0;
            acc_lo <= mag(bus.OpA, in_signed);
            cnt    <= '0;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (op[1]) begin
            // restoring step: keep the trial difference only when it did not borrow
            acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
            acc_hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (!abort) begin
            done <= 1'b1;
            if (!op[1]) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (opb == '0) begin
              hi  <= rem_fix;
              lo  <= '1;
              dbz <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quot_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy      = (state != IDLE);
  assign bus.Done      = done;
  assign bus.DivByZero = dbz;
  assign bus.Hi        = hi;
  assign bus.Lo        = lo;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the 32-bit 3:1 forwarding muxes.
- Consumes the forwarded operands OpA and OpB, then executes MULT, MULTU, DIV or DIVU over multiple cycles.
- Holds the architectural HI/LO registers.
- Drives Busy to the hazard unit so the pipeline stalls while an operation is in flight.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits. Iteration count equals WIDTH.

Ports:
- Clk  in  1  clock. All state updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  launch request; sampled only in IDLE.
- Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- OpA  in  WIDTH  rs operand from the forwarding mux.
- OpB  in  WIDTH  rt operand from the forwarding mux.
- HiWrite  in  1  MTHI strobe.
- LoWrite  in  1  MTLO strobe.
- WrData  in  WIDTH  MTHI/MTLO data.
- Busy  out  1  operation in flight; stall request.
- Done  out  1  one-cycle pulse when HI/LO are loaded with a result.
- DivByZero  out  1  one-cycle pulse, coincident with Done, for DIV/DIVU with OpB==0.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.

Behaviour:
- Reset (Rst=0, asynchronous): state IDLE, counter 0, Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0. A reset mid-operation abandons the operation; no partial result is ever written.
- States:
  - IDLE: Start=1 latches Op, |OpA|, |OpB| and the sign bits, clears the accumulator, counter=0, goes to RUN. Magnitude is taken only for signed ops (MULT, DIV); unsigned ops use the raw values.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Counter increments 0..WIDTH-1. At counter==WIDTH-1 go to FIX.
  - FIX: apply sign correction, load Hi/Lo, pulse Done, return to IDLE.
- Timing for Start sampled at edge k:
  - Busy=1 from after edge k until edge k+WIDTH+1, i.e. 33 cycles for WIDTH=32.
  - At edge k+WIDTH+1, Hi/Lo update, Done=1 for exactly one cycle, Busy=0.
- Multiply: 2·WIDTH-bit product, Hi = upper half, Lo = lower half. For MULT, negate the 64-bit product if signA^signB.
- Divide: Lo = quotient, Hi = remainder.
  - DIV quotient sign = signA^signB; remainder sign = signA.
  - DIV 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0 (wrap, no trap).
- Divide by zero (OpB==0 at Start): the operation still takes full latency. Then Hi=OpA as latched, Lo=all-ones, and DivByZero pulses with Done.
- Start while Busy: ignored, no queuing.
- HiWrite/LoWrite:
  - In IDLE: write WrData at the edge. If Start is asserted the same cycle, the write happens and the op is also launched; the op result later overwrites Hi/Lo.
  - While Busy: ignored.
  - HiWrite and LoWrite together: both registers take WrData.
- Hi/Lo hold their values in all other cycles. Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: MULDIV_ABORT_EN.
- Defined: adds input port Abort (1 bit, after Start).
  - Abort=1 in RUN or FIX returns to IDLE at the next edge: Hi/Lo unchanged, no Done, Busy=0 the following cycle.
  - Abort in IDLE has no effect.
  - Abort and Start in the same IDLE cycle: Start wins.
- Not defined: no Abort port; every accepted operation runs to completion.

Test Plan:
- MULT OpA=0xFFFFFFFD (-3), OpB=7 -> after 33 Busy cycles: Hi=0xFFFFFFFF, Lo=0xFFFFFFEB, Done pulses once, DivByZero=0.
- MULTU OpA=OpB=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- DIV OpA=0xFFFFFFF9 (-7), OpB=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU OpA=100, OpB=0 -> Hi=0x00000064, Lo=0xFFFFFFFF, DivByZero and Done both high for one cycle.
- MTHI 0x12345678 in IDLE, then MULTU 2*3 with Start re-pulsed at RUN count 5 and LoWrite pulsed at count 6 -> second Start and LoWrite ignored; final Hi=0, Lo=6; Busy stays high exactly 33 cycles.
- Rst low at RUN count 10 after a prior result Hi=0xAAAA, Lo=0x5555 -> Hi=Lo=0 and Busy=0 immediately (asynchronous). With MULDIV_ABORT_EN, Abort at count 10 instead -> Hi=0xAAAA, Lo=0x5555 retained, no Done.
